// File: rtl/fc_engine.sv
// Fully-connected layer engine: LANES signed MACs per cycle, one output neuron per pass.
// Define FC_RELU_EN to clamp negative saturated results to zero before they are written.
module fc_engine #(
  parameter int DATA_WIDTH     = 8,
  parameter int WEIGHT_WIDTH   = 4,
  parameter int LANES          = 20,
  parameter int IN_NUM         = 800,
  parameter int OUT_NUM        = 500,
  parameter int ACC_WIDTH      = 32,
  parameter int OUT_SHIFT      = 4,
  parameter int IN_ADDR_WIDTH  = 10,
  parameter int W_ADDR_WIDTH   = 15,
  parameter int OUT_ADDR_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            srst,
  input  logic                            fc_start,
  input  logic                            mem_sel,
  output logic                            busy,
  output logic                            fc_done,
  input  logic [LANES*DATA_WIDTH-1:0]     sram_rdata_c,
  input  logic [LANES*DATA_WIDTH-1:0]     sram_rdata_d,
  output logic [IN_ADDR_WIDTH-1:0]        sram_raddr_in,
  input  logic [LANES*WEIGHT_WIDTH-1:0]   sram_rdata_weight,
  output logic [W_ADDR_WIDTH-1:0]         sram_raddr_weight,
  output logic                            sram_write_enable_out,
  output logic [OUT_ADDR_WIDTH-1:0]       sram_waddr_out,
  output logic [DATA_WIDTH-1:0]           sram_wdata_out
);

  localparam int CHUNKS = IN_NUM / LANES;
  localparam int KW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int NW     = (OUT_NUM > 1) ? $clog2(OUT_NUM) : 1;
  localparam int PW     = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                         state;
  logic [KW-1:0]                  chunk_idx;
  logic [NW-1:0]                  neuron_idx;
  logic [W_ADDR_WIDTH-1:0]        wbase;
  logic                           sel_q;
  logic                           vld_p0;
  logic signed [ACC_WIDTH-1:0]    acc_p1;
  logic signed [ACC_WIDTH-1:0]    psum_p0;
  logic [LANES*DATA_WIDTH-1:0]    src_word;
  logic [KW-1:0]                  chunk_nxt;

  function automatic logic signed [PW-1:0] lane_prod(
    input logic signed [DATA_WIDTH-1:0]   a,
    input logic signed [WEIGHT_WIDTH-1:0] b
  );
    return a * b;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_shift(
    input logic signed [ACC_WIDTH-1:0] a
  );
    logic signed [ACC_WIDTH-1:0] s;
    s = a >>> OUT_SHIFT;
    if (s > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
    if (s < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
    return s[DATA_WIDTH-1:0];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] out_fn(
    input logic signed [DATA_WIDTH-1:0] v
  );
`ifdef FC_RELU_EN
    return v[DATA_WIDTH-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign src_word  = sel_q ? sram_rdata_d : sram_rdata_c;
  assign chunk_nxt = chunk_idx + KW'(1);

  // Stage p0: SRAM words arriving this cycle reduced to one full-precision lane sum
  always_comb begin
    psum_p0 = '0;
    for (int i = 0; i < LANES; i++) begin
      psum_p0 = psum_p0 + ACC_WIDTH'(lane_prod(src_word[i*DATA_WIDTH +: DATA_WIDTH],
                                               sram_rdata_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
    end
  end

  // Stage p1: accumulator plus the control FSM; outputs are registered alongside state
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state                 <= S_IDLE;
      chunk_idx             <= '0;
      neuron_idx            <= '0;
      wbase                 <= '0;
      sel_q                 <= 1'b0;
      vld_p0                <= 1'b0;
      acc_p1                <= '0;
      busy                  <= 1'b0;
      fc_done               <= 1'b0;
      sram_raddr_in         <= '0;
      sram_raddr_weight     <= '0;
      sram_write_enable_out <= 1'b0;
      sram_waddr_out        <= '0;
      sram_wdata_out        <= '0;
    end else begin
      sram_write_enable_out <= 1'b0;
      sram_waddr_out        <= '0;
      sram_wdata_out        <= '0;
      sram_raddr_in         <= '0;
      sram_raddr_weight     <= '0;
      fc_done               <= 1'b0;
      vld_p0                <= (state == S_RUN);
      if (vld_p0) acc_p1 <= acc_p1 + psum_p0;
      case (state)
        S_IDLE: begin
          if (fc_start) begin
            sel_q      <= mem_sel;
            chunk_idx  <= '0;
            neuron_idx <= '0;
            wbase      <= '0;
            acc_p1     <= '0;
            busy       <= 1'b1;
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (chunk_idx == KW'(CHUNKS - 1)) begin
            state <= S_DRAIN;
          end else begin
            chunk_idx         <= chunk_nxt;
            sram_raddr_in     <= IN_ADDR_WIDTH'(chunk_nxt);
            sram_raddr_weight <= wbase + W_ADDR_WIDTH'(chunk_nxt);
          end
        end
        S_DRAIN: begin
          // Last chunk lands this cycle, so the written value folds it in directly
          sram_write_enable_out <= 1'b1;
          sram_waddr_out        <= OUT_ADDR_WIDTH'(neuron_idx);
          sram_wdata_out        <= out_fn(sat_shift(acc_p1 + psum_p0));
          state                 <= S_WRITE;
        end
        S_WRITE: begin
          acc_p1    <= '0;
          chunk_idx <= '0;
          if (neuron_idx == NW'(OUT_NUM - 1)) begin
            fc_done <= 1'b1;
            state   <= S_DONE;
          end else begin
            neuron_idx        <= neuron_idx + NW'(1);
            wbase             <= wbase + W_ADDR_WIDTH'(CHUNKS);
            sram_raddr_weight <= wbase + W_ADDR_WIDTH'(CHUNKS);
            state             <= S_RUN;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_engine.sv
// Bench for fc_engine: table of uniform-fill vectors plus random-content runs, scoreboard on writes.
module tb_fc_engine;
  localparam int DW = 8, WW = 4, L = 4, IN = 8, ON = 2, CH = IN / L;

  logic clk = 1'b0, srst = 1'b1, fc_start = 1'b0, mem_sel = 1'b0;
  logic [L*DW-1:0] rdc, rdd;
  logic [L*WW-1:0] rdw;
  logic            busy_a, done_a, we_a, busy_b, done_b, we_b;
  logic [9:0]      rin_a, rin_b, waddr_a, waddr_b;
  logic [14:0]     rw_a, rw_b;
  logic [DW-1:0]   wdata_a, wdata_b;

  fc_engine #(.LANES(L), .IN_NUM(IN), .OUT_NUM(ON), .OUT_SHIFT(0)) u_dut (
    .clk(clk), .srst(srst), .fc_start(fc_start), .mem_sel(mem_sel), .busy(busy_a), .fc_done(done_a),
    .sram_rdata_c(rdc), .sram_rdata_d(rdd), .sram_raddr_in(rin_a), .sram_rdata_weight(rdw),
    .sram_raddr_weight(rw_a), .sram_write_enable_out(we_a), .sram_waddr_out(waddr_a),
    .sram_wdata_out(wdata_a));

  fc_engine #(.LANES(L), .IN_NUM(IN), .OUT_NUM(ON), .OUT_SHIFT(2)) u_dut2 (
    .clk(clk), .srst(srst), .fc_start(fc_start), .mem_sel(mem_sel), .busy(busy_b), .fc_done(done_b),
    .sram_rdata_c(rdc), .sram_rdata_d(rdd), .sram_raddr_in(rin_b), .sram_rdata_weight(rdw),
    .sram_raddr_weight(rw_b), .sram_write_enable_out(we_b), .sram_waddr_out(waddr_b),
    .sram_wdata_out(wdata_b));

  always #5 clk = ~clk;

  int mc[CH][L], md[CH][L], mw[ON*CH][L];
  int errors = 0, checks = 0, wr_cnt = 0, done_cnt = 0;

  typedef struct { int addr; int data; } wr_t;
  wr_t q0[$], q2[$];

  typedef struct { int dc; int dd; int w; bit sel; int e0; int e2; } vec_t;
  vec_t vecs[8];

  // One-cycle-latency SRAM models addressed by the shift-0 instance
  always @(posedge clk) begin
    for (int i = 0; i < L; i++) begin
      rdc[i*DW +: DW] <= DW'(mc[rin_a[0]][i]);
      rdd[i*DW +: DW] <= DW'(md[rin_a[0]][i]);
      rdw[i*WW +: WW] <= WW'(mw[rw_a[1:0]][i]);
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int post(input int v);
`ifdef FC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int model(input int n, input bit sel, input int sh);
    int acc = 0;
    for (int k = 0; k < CH; k++)
      for (int i = 0; i < L; i++)
        acc += (sel ? md[k][i] : mc[k][i]) * mw[n*CH+k][i];
    acc = acc >>> sh;
    if (acc > 127) acc = 127;
    if (acc < -128) acc = -128;
    return post(acc);
  endfunction

  always @(negedge clk) begin
    wr_t e;
    if (we_a) begin
      wr_cnt++;
      if (q0.size() == 0) chk("unexpected_write_a", 1, 0);
      else begin
        e = q0.pop_front();
        chk("waddr_a", int'(waddr_a), e.addr);
        chk("wdata_a", int'($signed(wdata_a)), e.data);
      end
    end else chk("wr_idle_a", int'(waddr_a) + int'(wdata_a), 0);
    if (we_b) begin
      if (q2.size() == 0) chk("unexpected_write_b", 1, 0);
      else begin
        e = q2.pop_front();
        chk("waddr_b", int'(waddr_b), e.addr);
        chk("wdata_b", int'($signed(wdata_b)), e.data);
      end
    end
    if (done_a) done_cnt++;
  end

  task automatic fill_uniform(input int dc, input int dd, input int w);
    for (int k = 0; k < CH; k++)
      for (int i = 0; i < L; i++) begin mc[k][i] = dc; md[k][i] = dd; end
    for (int r = 0; r < ON*CH; r++)
      for (int i = 0; i < L; i++) mw[r][i] = w;
  endtask

  task automatic fill_random();
    for (int k = 0; k < CH; k++)
      for (int i = 0; i < L; i++) begin
        mc[k][i] = int'($urandom_range(0, 255)) - 128;
        md[k][i] = int'($urandom_range(0, 255)) - 128;
      end
    for (int r = 0; r < ON*CH; r++)
      for (int i = 0; i < L; i++) mw[r][i] = int'($urandom_range(0, 15)) - 8;
  endtask

  task automatic push_model(input bit sel);
    for (int n = 0; n < ON; n++) begin
      q0.push_back('{n, model(n, sel, 0)});
      q2.push_back('{n, model(n, sel, 2)});
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_we"}, int'(we_a), 0);
    chk({tag, "_raddr_in"}, int'(rin_a), 0);
    chk({tag, "_raddr_w"}, int'(rw_a), 0);
    chk({tag, "_waddr"}, int'(waddr_a), 0);
    chk({tag, "_wdata"}, int'(wdata_a), 0);
  endtask

  task automatic run_fc(input bit sel, input bit toggle, input bit spam);
    int cyc, w0, d0;
    w0 = wr_cnt; d0 = done_cnt;
    @(negedge clk); fc_start = 1'b1; mem_sel = sel;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      fc_start = spam && (cyc % 2 == 0) && (cyc < 8);
      if (toggle && cyc >= 3) mem_sel = ~mem_sel;
      if (cyc == 1) chk("busy_run", int'(busy_a), 1);
    end while (!done_a && cyc < 40);
    fc_start = 1'b0;
    chk("done_latency", cyc, 9);
    @(negedge clk);
    chk("done_pulse", int'(done_a), 0);
    chk("busy_idle", int'(busy_a), 0);
    repeat (3) @(negedge clk);
    chk("write_count", wr_cnt - w0, 2);
    chk("done_count", done_cnt - d0, 1);
    chk("queue_empty", q0.size() + q2.size(), 0);
    mem_sel = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1, 1, 1, 1'b0, 8, 2};
    vecs[1] = '{127, 127, 7, 1'b0, 127, 127};
    vecs[2] = '{-128, -128, 7, 1'b0, -128, -128};
    vecs[3] = '{3, 3, -5, 1'b0, -120, -30};
    vecs[4] = '{2, 5, 3, 1'b1, 120, 30};
    vecs[5] = '{-1, -1, -8, 1'b0, 64, 16};
    vecs[6] = '{16, 16, 1, 1'b0, 127, 32};
    vecs[7] = '{-17, -17, 1, 1'b0, -128, -34};
    fill_uniform(0, 0, 0);

    repeat (2) @(negedge clk);
    check_zero("reset");
    srst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      fill_uniform(vecs[v].dc, vecs[v].dd, vecs[v].w);
      for (int n = 0; n < ON; n++) begin
        q0.push_back('{n, post(vecs[v].e0)});
        q2.push_back('{n, post(vecs[v].e2)});
      end
      run_fc(vecs[v].sel, 1'b0, 1'b0);
    end

    // Bank d selected at start, mem_sel toggling mid-run
    fill_random();
    push_model(1'b1);
    run_fc(1'b1, 1'b1, 1'b0);
    fill_random();
    push_model(1'b0);
    run_fc(1'b0, 1'b1, 1'b0);

    // Repeated fc_start while busy
    fill_random();
    push_model(1'b0);
    run_fc(1'b0, 1'b0, 1'b1);

    // Reset in cycle 3 of a run, then a clean rerun
    fill_random();
    begin
      int w0;
      w0 = wr_cnt;
      @(negedge clk); fc_start = 1'b1;
      @(negedge clk); fc_start = 1'b0;
      repeat (2) @(negedge clk);
      srst = 1'b1;
      #1;
      check_zero("midreset");
      repeat (4) @(negedge clk);
      srst = 1'b0;
      chk("midreset_no_write", wr_cnt - w0, 0);
    end
    push_model(1'b0);
    run_fc(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end
endmodule
